tile_stream_serializer: RTL and testbench
=========================================

Name: tile_stream_serializer

Overview:
- Sits directly downstream of the tilling machine. Captures each completed output tile (SIZE_OF_PRSC_OUTPUT rows x 2*SIZE_OF_PRSC_OUTPUT columns of PIX_WIDTH pixels).
- Streams each tile out in raster order, PIX_PER_BEAT pixels per beat, on a valid/ready interface toward the output writer.
- Holds tiles in a two-slot ping-pong buffer, so one tile can arrive while the previous one drains.

Parameters:
- PIX_WIDTH, 16, bits per pixel.
- SIZE_OF_PRSC_OUTPUT, 6, tile rows (ROWS); tile columns COLS = 2*SIZE_OF_PRSC_OUTPUT.
- PIX_PER_BEAT, 2, pixels per output beat. Must divide COLS; elaboration error otherwise.
- BEATS_PER_ROW, COLS/PIX_PER_BEAT, derived.
- BEATS_PER_TILE, ROWS*BEATS_PER_ROW, derived (36 at defaults).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-low.
- tile_valid_i  in  1  tile-valid level from tilling machine.
- tile_data_i  in  ROWS*COLS*PIX_WIDTH  tile. Pixel (r,c) at bits [(r*COLS+c)*PIX_WIDTH +: PIX_WIDTH].
- tile_ready_o  out  1  high when at least one slot is free.
- pix_valid_o  out  1  output beat valid.
- pix_data_o  out  PIX_PER_BEAT*PIX_WIDTH  beat. Lane k = pixel (row, col+k) at bits [k*PIX_WIDTH +: PIX_WIDTH].
- pix_row_o  out  clog2(ROWS)  row of current beat.
- pix_col_o  out  clog2(COLS)  first column of current beat.
- pix_last_o  out  1  last beat of tile.
- pix_ready_i  in  1  downstream accepts beat.
- overflow_o  out  1  sticky: a tile was dropped.
- tile_count_o  out  16  tiles fully streamed, wraps at 2^16.

Behaviour:
- Reset (async, rst_i=0):
  - Outputs: pix_valid_o=0, pix_data_o=0, pix_row_o=0, pix_col_o=0, pix_last_o=0, overflow_o=0, tile_count_o=0, tile_ready_o=1.
  - Internal state: slots empty, wr_sel=rd_sel=0, beat counter=0, FSM=IDLE, tile_valid_d=0.
  - Reset mid-stream discards all buffered tiles; no partial beat is emitted afterwards.
- Capture:
  - tile_valid_d registers tile_valid_i. Capture event = tile_valid_i & ~tile_valid_d (rising edge). A level held for N cycles is one tile.
  - Event with occupancy<2: tile_data_i is written into slot wr_sel, the slot is marked full, wr_sel toggles.
  - Event with occupancy==2: tile is dropped, overflow_o set to 1 and held until reset.
  - tile_ready_o = (occupancy<2), taken from registered occupancy. A slot released in the same cycle does not make room for a capture in that cycle; that capture is dropped.
- Readout FSM:
  - IDLE: if slot rd_sel is full -> STREAM next cycle with beat 0 presented (capture-to-first-beat latency 2 cycles from the rising edge).
  - STREAM:
    - pix_valid_o=1. Registered outputs are held stable while pix_valid_o & ~pix_ready_i.
    - On a handshake (pix_valid_o & pix_ready_i): beat counter increments, col advances by PIX_PER_BEAT, wraps to 0 with row+1 at COLS.
    - pix_last_o=1 only on beat BEATS_PER_TILE-1 (row ROWS-1, col COLS-PIX_PER_BEAT).
  - Last-beat handshake:
    - Slot rd_sel is marked empty, rd_sel toggles, tile_count_o increments.
    - If the other slot is full: stay in STREAM and present its beat 0 next cycle (no bubble).
    - Otherwise go to IDLE and drop pix_valid_o to 0.
  - pix_valid_o never deasserts without a handshake, except on reset.
- Simultaneous capture and last-beat release: occupancy is unchanged (+1 -1). Slot indices stay consistent because capture writes wr_sel and release frees rd_sel, which differ whenever both are valid.
- A capture into slot rd_sel while in IDLE is legal. The FSM sees the slot full on the following cycle.
- Beat data muxing is combinational from the slot to the output register only; no arithmetic on pixels.

Test Plan:
- Single tile, pixel value = r*COLS+c, pix_ready_i=1 -> 36 beats starting 2 cycles after the edge. Beat 0 = {1,0}, beat 35 = {71,70} with pix_last_o=1; tile_count_o=1; back to IDLE.
- Backpressure: pix_ready_i toggles 1,0,0,1,... -> data/row/col stable during stalls; exactly 36 handshakes, in order, no duplicates.
- Back-to-back: second edge arrives mid-stream of tile A -> tile B beat 0 follows A's last beat the next cycle with no bubble; tile_count_o=2.
- Overflow: pix_ready_i=0, three rising edges -> first two stored, third dropped; tile_ready_o=0 after the second; overflow_o=1 sticky. Release ready -> exactly 72 beats out.
- Level hold: tile_valid_i held high 10 cycles -> exactly one tile captured.
- Reset mid-stream at beat 17 -> all outputs 0 immediately. A later new tile streams from beat 0, tile_count_o restarts at 0.

Source files
------------

// File: rtl/tile_stream_serializer_if.sv
// Tile-in / beat-out bundle for tile_stream_serializer.
// The slave modport is the serializer; the master modport is the tile
// source plus the output writer (or a bench standing in for both).
// Handshake rules: a tile is offered by a rising edge of tile_valid_i and is
// captured only while tile_ready_o is high. A beat transfers on any clock
// edge where pix_valid_o & pix_ready_i. Once pix_valid_o is raised, it and
// the beat fields stay unchanged until that transfer happens.
interface tile_stream_serializer_if #(
  parameter int PIX_WIDTH           = 16,
  parameter int SIZE_OF_PRSC_OUTPUT = 6,
  parameter int PIX_PER_BEAT        = 2
);
  localparam int ROWS = SIZE_OF_PRSC_OUTPUT;
  localparam int COLS = 2 * SIZE_OF_PRSC_OUTPUT;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;

  logic                              tile_valid_i;
  logic [ROWS*COLS*PIX_WIDTH-1:0]    tile_data_i;
  logic                              tile_ready_o;
  logic                              pix_valid_o;
  logic [PIX_PER_BEAT*PIX_WIDTH-1:0] pix_data_o;
  logic [RW-1:0]                     pix_row_o;
  logic [CW-1:0]                     pix_col_o;
  logic                              pix_last_o;
  logic                              pix_ready_i;

  modport slave (
    input  tile_valid_i, tile_data_i, pix_ready_i,
    output tile_ready_o, pix_valid_o, pix_data_o, pix_row_o, pix_col_o, pix_last_o
  );

  modport master (
    output tile_valid_i, tile_data_i, pix_ready_i,
    input  tile_ready_o, pix_valid_o, pix_data_o, pix_row_o, pix_col_o, pix_last_o
  );
endinterface

// File: rtl/tile_stream_serializer.sv
// Captures complete tiles into a two-slot ping-pong buffer and streams each
// tile out in raster order, PIX_PER_BEAT pixels per beat.
// Beat outputs are registered; the slot-to-beat mux is the only logic on the
// pixel path.
module tile_stream_serializer #(
  parameter int PIX_WIDTH           = 16,
  parameter int SIZE_OF_PRSC_OUTPUT = 6,
  parameter int PIX_PER_BEAT        = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  tile_stream_serializer_if.slave     bus,
  output logic                        overflow_o,
  output logic [15:0]                 tile_count_o,
  output logic                        dbg_state_o
);
  localparam int ROWS   = SIZE_OF_PRSC_OUTPUT;
  localparam int COLS   = 2 * SIZE_OF_PRSC_OUTPUT;
  localparam int BPR    = COLS / PIX_PER_BEAT;
  localparam int BPT    = ROWS * BPR;
  localparam int TILE_W = ROWS * COLS * PIX_WIDTH;
  localparam int BEAT_W = PIX_PER_BEAT * PIX_WIDTH;
  localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW     = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int BW     = (BPT > 1) ? $clog2(BPT) : 1;

  generate
    if ((COLS % PIX_PER_BEAT) != 0) begin : g_bad_ppb
      $error("PIX_PER_BEAT must divide 2*SIZE_OF_PRSC_OUTPUT");
    end
  endgenerate

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_tile_valid_d;
  logic [1:0]          r_full;
  logic                r_wr_sel;
  logic                r_rd_sel;
  logic [TILE_W-1:0]   r_slot [2];

  logic [BW-1:0]       r_beat;
  logic [RW-1:0]       r_row;
  logic [CW-1:0]       r_col;
  logic [BEAT_W-1:0]   r_pix_data;
  logic                r_pix_valid;
  logic                r_pix_last;
  logic                r_overflow;
  logic [15:0]         r_tile_count;

  logic                w_cap;
  logic                w_store;
  logic                w_drop;
  logic                w_hs;
  logic                w_col_wrap;
  logic [CW-1:0]       w_next_col;
  logic [RW-1:0]       w_next_row;
  logic                w_load;
  logic                w_load_sel;
  logic [BW-1:0]       w_load_beat;
  logic [RW-1:0]       w_load_row;
  logic [CW-1:0]       w_load_col;
  logic                w_release;
  logic                w_clear;
  logic [TILE_W-1:0]   w_slot_q;
  logic [BEAT_W-1:0]   w_beat_data;

  // A tile is one rising edge of the valid level; it is stored only if a
  // slot was already free at the start of the cycle.
  assign w_cap   = bus.tile_valid_i & ~r_tile_valid_d;
  assign w_store = w_cap & ~(&r_full);
  assign w_drop  = w_cap & (&r_full);
  assign w_hs    = r_pix_valid & bus.pix_ready_i;

  // Raster position of the beat after the one currently presented.
  assign w_col_wrap = (r_col == CW'(COLS - PIX_PER_BEAT));
  assign w_next_col = w_col_wrap ? '0 : r_col + CW'(PIX_PER_BEAT);
  assign w_next_row = w_col_wrap ? r_row + RW'(1) : r_row;

  // Beat b of a tile is a contiguous slice because lanes are adjacent columns.
  assign w_slot_q    = r_slot[w_load_sel];
  assign w_beat_data = w_slot_q[int'(w_load_beat)*BEAT_W +: BEAT_W];

  // Readout state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Readout next state: choose which beat (if any) to load into the outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_sel  = r_rd_sel;
    w_load_beat = '0;
    w_load_row  = '0;
    w_load_col  = '0;
    w_release   = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_full[r_rd_sel]) begin
          w_state_nxt = S_STREAM;
          w_load      = 1'b1;
        end
      end
      S_STREAM: begin
        if (w_hs) begin
          if (r_pix_last) begin
            w_release = 1'b1;
            if (r_full[~r_rd_sel]) begin
              // Next tile already waiting: its beat 0 follows with no bubble.
              w_load     = 1'b1;
              w_load_sel = ~r_rd_sel;
            end else begin
              w_state_nxt = S_IDLE;
              w_clear     = 1'b1;
            end
          end else begin
            w_load      = 1'b1;
            w_load_beat = r_beat + BW'(1);
            w_load_row  = w_next_row;
            w_load_col  = w_next_col;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Edge detect, slot occupancy, selectors and status counters.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_tile_valid_d <= 1'b0;
      r_full         <= 2'b00;
      r_wr_sel       <= 1'b0;
      r_rd_sel       <= 1'b0;
      r_overflow     <= 1'b0;
      r_tile_count   <= '0;
    end else begin
      r_tile_valid_d <= bus.tile_valid_i;
      // Release and capture never touch the same slot when both happen.
      if (w_release) begin
        r_full[r_rd_sel] <= 1'b0;
        r_rd_sel         <= ~r_rd_sel;
        r_tile_count     <= r_tile_count + 16'd1;
      end
      if (w_store) begin
        r_full[r_wr_sel] <= 1'b1;
        r_wr_sel         <= ~r_wr_sel;
      end
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Tile storage; contents are only read while the slot is marked full.
  always_ff @(posedge clk_i) begin
    if (w_store) r_slot[r_wr_sel] <= bus.tile_data_i;
  end

  // Registered beat outputs, held while stalled.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_beat      <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_pix_data  <= '0;
      r_pix_valid <= 1'b0;
      r_pix_last  <= 1'b0;
    end else if (w_load) begin
      r_beat      <= w_load_beat;
      r_row       <= w_load_row;
      r_col       <= w_load_col;
      r_pix_data  <= w_beat_data;
      r_pix_valid <= 1'b1;
      r_pix_last  <= (w_load_beat == BW'(BPT - 1));
    end else if (w_clear) begin
      r_beat      <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_pix_data  <= '0;
      r_pix_valid <= 1'b0;
      r_pix_last  <= 1'b0;
    end
  end

  assign bus.tile_ready_o = ~(&r_full);
  assign bus.pix_valid_o  = r_pix_valid;
  assign bus.pix_data_o   = r_pix_data;
  assign bus.pix_row_o    = r_row;
  assign bus.pix_col_o    = r_col;
  assign bus.pix_last_o   = r_pix_last;
  assign overflow_o       = r_overflow;
  assign tile_count_o     = r_tile_count;
  assign dbg_state_o      = r_state;
endmodule

// File: tb/tb_tile_stream_serializer.sv
// Directed bench for tile_stream_serializer at default parameters
// (6x12 tile of 16-bit pixels, 2 pixels per beat, 36 beats per tile).
module tb_tile_stream_serializer;
  localparam int PW     = 16;
  localparam int ROWS   = 6;
  localparam int COLS   = 12;
  localparam int PPB    = 2;
  localparam int BPR    = COLS / PPB;
  localparam int BPT    = ROWS * BPR;
  localparam int TILE_W = ROWS * COLS * PW;
  localparam int W      = 2 * PW + 3 + 4 + 1;

  logic        clk_i;
  logic        rst_i;
  logic        overflow_o;
  logic [15:0] tile_count_o;
  logic        dbg_state;

  int          n_checks;
  int          n_fail;
  int          n_hs;
  logic [31:0] last_data;
  logic [W-1:0] exp_q[$];

  tile_stream_serializer_if #(.PIX_WIDTH(PW), .SIZE_OF_PRSC_OUTPUT(6), .PIX_PER_BEAT(PPB)) bus ();

  tile_stream_serializer #(.PIX_WIDTH(PW), .SIZE_OF_PRSC_OUTPUT(6), .PIX_PER_BEAT(PPB)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .bus          (bus.slave),
    .overflow_o   (overflow_o),
    .tile_count_o (tile_count_o),
    .dbg_state_o  (dbg_state)
  );

  // Clock and watchdog.
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [TILE_W-1:0] mk_tile(input int base);
    logic [TILE_W-1:0] t;
    t = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        t[(r*COLS+c)*PW +: PW] = 16'(base + r*COLS + c);
    return t;
  endfunction

  // Scoreboard entry per beat: {lane1, lane0, row, col, last}.
  task automatic push_tile(input int base);
    int row, col;
    logic [31:0] d;
    for (int b = 0; b < BPT; b++) begin
      row = b / BPR;
      col = (b % BPR) * PPB;
      d   = {16'(base + row*COLS + col + 1), 16'(base + row*COLS + col)};
      exp_q.push_back({d, 3'(row), 4'(col), (b == BPT-1)});
    end
  endtask

  // One clock: score the beat that will transfer at the coming edge, then
  // verify stall stability and back-to-back continuity on the next sample.
  task automatic cycle();
    logic [W-1:0] obs;
    logic [W-1:0] held;
    logic [W-1:0] e;
    logic         stalled;
    logic         last_hs;
    obs     = {bus.pix_data_o, bus.pix_row_o, bus.pix_col_o, bus.pix_last_o};
    held    = obs;
    stalled = 1'b0;
    last_hs = 1'b0;
    if (bus.pix_valid_o && bus.pix_ready_i) begin
      n_hs++;
      if (exp_q.size() == 0) begin
        check("extra_beat", 64'(obs), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("beat", 64'(obs), 64'(e));
      end
      if (bus.pix_last_o) begin
        last_data = bus.pix_data_o;
        last_hs   = 1'b1;
      end
    end else if (bus.pix_valid_o) begin
      stalled = 1'b1;
    end
    @(posedge clk_i);
    @(negedge clk_i);
    if (stalled) begin
      check("stall_valid", 64'(bus.pix_valid_o), 64'(1));
      check("stall_hold", 64'({bus.pix_data_o, bus.pix_row_o, bus.pix_col_o, bus.pix_last_o}), 64'(held));
    end
    if (last_hs && exp_q.size() > 0)
      check("no_bubble", 64'(bus.pix_valid_o), 64'(1));
  endtask

  // mode 0: ready always high; mode 1: ready pattern 1,0,0 repeating.
  task automatic drain(input int mode, input int max_cyc);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < max_cyc) begin
      bus.pix_ready_i = (mode == 0) ? 1'b1 : ((k % 3) == 0);
      cycle();
      k++;
    end
    check("drain_done", 64'(exp_q.size()), 64'(0));
    bus.pix_ready_i = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Pulse tile_valid_i for one cycle with the given tile contents.
  task automatic pulse_tile(input int base);
    bus.tile_data_i  = mk_tile(base);
    bus.tile_valid_i = 1'b1;
    cycle();
    bus.tile_valid_i = 1'b0;
  endtask

  int hs0;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    n_hs     = 0;
    last_data = '0;
    rst_i            = 1'b0;
    bus.tile_valid_i = 1'b0;
    bus.tile_data_i  = '0;
    bus.pix_ready_i  = 1'b0;
    repeat (3) @(negedge clk_i);

    // Reset state.
    check("rst_pix_valid", 64'(bus.pix_valid_o), 64'(0));
    check("rst_pix_data", 64'(bus.pix_data_o), 64'(0));
    check("rst_pix_row", 64'(bus.pix_row_o), 64'(0));
    check("rst_pix_col", 64'(bus.pix_col_o), 64'(0));
    check("rst_pix_last", 64'(bus.pix_last_o), 64'(0));
    check("rst_overflow", 64'(overflow_o), 64'(0));
    check("rst_tile_count", 64'(tile_count_o), 64'(0));
    check("rst_tile_ready", 64'(bus.tile_ready_o), 64'(1));
    check("rst_state", 64'(dbg_state), 64'(0));
    rst_i = 1'b1;
    idle(2);

    // Single tile, ready high, two-cycle latency.
    bus.pix_ready_i = 1'b1;
    push_tile(0);
    pulse_tile(0);
    check("lat_not_yet", 64'(bus.pix_valid_o), 64'(0));
    cycle();
    check("lat_valid", 64'(bus.pix_valid_o), 64'(1));
    check("beat0_data", 64'(bus.pix_data_o), 64'(32'h0001_0000));
    check("beat0_row", 64'(bus.pix_row_o), 64'(0));
    check("beat0_col", 64'(bus.pix_col_o), 64'(0));
    drain(0, 100);
    check("beat35_data", 64'(last_data), 64'(32'h0047_0046));
    check("single_count", 64'(tile_count_o), 64'(1));
    check("single_idle_valid", 64'(bus.pix_valid_o), 64'(0));
    check("single_idle_state", 64'(dbg_state), 64'(0));
    idle(3);

    // Backpressure.
    hs0 = n_hs;
    push_tile(200);
    pulse_tile(200);
    drain(1, 400);
    check("bp_handshakes", 64'(n_hs - hs0), 64'(36));
    check("bp_count", 64'(tile_count_o), 64'(2));
    idle(3);

    // Back-to-back: tile B arrives while tile A streams.
    push_tile(300);
    pulse_tile(300);
    idle(10);
    push_tile(400);
    pulse_tile(400);
    drain(0, 200);
    check("b2b_count", 64'(tile_count_o), 64'(4));
    idle(3);

    // Overflow: ready low, three edges, third dropped.
    bus.pix_ready_i = 1'b0;
    push_tile(500);
    pulse_tile(500);
    cycle();
    check("ovf_ready_one", 64'(bus.tile_ready_o), 64'(1));
    push_tile(600);
    pulse_tile(600);
    check("ovf_ready_full", 64'(bus.tile_ready_o), 64'(0));
    check("ovf_not_yet", 64'(overflow_o), 64'(0));
    cycle();
    pulse_tile(700);
    check("ovf_set", 64'(overflow_o), 64'(1));
    cycle();
    check("ovf_ready_still", 64'(bus.tile_ready_o), 64'(0));
    hs0 = n_hs;
    drain(0, 200);
    check("ovf_handshakes", 64'(n_hs - hs0), 64'(72));
    check("ovf_sticky", 64'(overflow_o), 64'(1));
    check("ovf_count", 64'(tile_count_o), 64'(6));
    idle(3);

    // Level hold: one tile for a 10-cycle high level.
    push_tile(800);
    bus.tile_data_i  = mk_tile(800);
    bus.tile_valid_i = 1'b1;
    idle(10);
    bus.tile_valid_i = 1'b0;
    drain(0, 200);
    idle(6);
    check("level_count", 64'(tile_count_o), 64'(7));
    check("level_idle", 64'(bus.pix_valid_o), 64'(0));

    // Reset in the middle of a tile at beat 17.
    push_tile(900);
    pulse_tile(900);
    idle(18);
    check("mid_row", 64'(bus.pix_row_o), 64'(2));
    check("mid_col", 64'(bus.pix_col_o), 64'(10));
    rst_i = 1'b0;
    #1;
    check("mrst_valid", 64'(bus.pix_valid_o), 64'(0));
    check("mrst_data", 64'(bus.pix_data_o), 64'(0));
    check("mrst_row", 64'(bus.pix_row_o), 64'(0));
    check("mrst_col", 64'(bus.pix_col_o), 64'(0));
    check("mrst_last", 64'(bus.pix_last_o), 64'(0));
    check("mrst_count", 64'(tile_count_o), 64'(0));
    check("mrst_overflow", 64'(overflow_o), 64'(0));
    check("mrst_tile_ready", 64'(bus.tile_ready_o), 64'(1));
    exp_q.delete();
    @(negedge clk_i);
    rst_i = 1'b1;
    idle(2);
    check("post_rst_quiet", 64'(bus.pix_valid_o), 64'(0));
    push_tile(1000);
    pulse_tile(1000);
    cycle();
    check("post_rst_row", 64'(bus.pix_row_o), 64'(0));
    check("post_rst_col", 64'(bus.pix_col_o), 64'(0));
    drain(0, 100);
    idle(3);
    check("post_rst_count", 64'(tile_count_o), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
